dmem_arbiter: RTL and testbench

//  Two-port arbiter/sequencer for the byte-addressed data memory (DATAMEM-style port:

---
 rtl/dmem_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter/sequencer in front of a byte-addressed data memory.
// Port 0 is the CPU load/store unit, port 1 a debug/DMA master. One request is
// granted at a time. Each grant runs IDLE -> ACCESS -> RESP and performs at most
// one memory access. The result comes back as a registered ack pulse.
`timescale 1ns/1ps

module dmem_arbiter #(
    parameter int unsigned ADDR_W        = 9,
    parameter int unsigned DATA_W        = 32,
    parameter int unsigned PRIORITY_MODE = 0
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req0,
    input  logic              we0,
    input  logic [2:0]        op0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              ack0,
    output logic              err0,
    output logic [DATA_W-1:0] rdata0,

    input  logic              req1,
    input  logic              we1,
    input  logic [2:0]        op1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack1,
    output logic              err1,
    output logic [DATA_W-1:0] rdata1,

    output logic              busy,

    output logic              memwrite,
    output logic              memread,
    output logic [2:0]        memop,
    output logic [ADDR_W-1:0] memaddr,
    output logic [DATA_W-1:0] memdatain,
    input  logic [DATA_W-1:0] memdataout
);

    // Memory opcode encodings
    localparam logic [2:0] OP_B  = 3'b000;
    localparam logic [2:0] OP_H  = 3'b001;
    localparam logic [2:0] OP_W  = 3'b010;
    localparam logic [2:0] OP_BU = 3'b100;
    localparam logic [2:0] OP_HU = 3'b101;

    // Round-robin arbitration is selected when PRIORITY_MODE is 0
    localparam bit ROUND_ROBIN = (PRIORITY_MODE == 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t              state;

    // Latched request of the current grant
    logic                lat_id;
    logic                lat_we;
    logic [2:0]          lat_op;
    logic [ADDR_W-1:0]   lat_addr;
    logic [DATA_W-1:0]   lat_wdata;

    // Port granted most recently while both ports were contending
    logic                last_grant;

    // Arbitration result for the current cycle
    logic                grant_id;
    logic                any_req;

    // Legality of the latched request
    logic                illegal;
    logic                load_ok;

    // Pick the winning port among the active requests
    always_comb begin
        any_req  = req0 | req1;
        grant_id = 1'b0;
        if (req0 && req1) begin
            grant_id = ROUND_ROBIN ? ~last_grant : 1'b0;
        end else if (req1) begin
            grant_id = 1'b1;
        end
    end

    // Classify the latched request: reserved ops, misalignment, unsigned stores
    always_comb begin
        illegal = 1'b0;
        case (lat_op)
            OP_B, OP_BU: illegal = 1'b0;
            OP_H, OP_HU: illegal = lat_addr[0];
            OP_W:        illegal = |lat_addr[1:0];
            default:     illegal = 1'b1;
        endcase
        if (lat_we && ((lat_op == OP_BU) || (lat_op == OP_HU))) begin
            illegal = 1'b1;
        end
        load_ok = ~lat_we & ~illegal;
    end

    // Memory strobes exist only in ACCESS; a reset in that cycle kills the write
    always_comb begin
        memwrite = 1'b0;
        memread  = 1'b0;
        if (state == ACCESS && !illegal) begin
            memwrite = lat_we & ~rst;
            memread  = ~lat_we;
        end
    end

    // Address, op and write data always reflect the latched request
    assign memop     = lat_op;
    assign memaddr   = lat_addr;
    assign memdatain = lat_wdata;
    assign busy      = (state != IDLE);

    // Sequencer: latch a grant, perform the access, then return the response
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            lat_id     <= 1'b0;
            lat_we     <= 1'b0;
            lat_op     <= 3'b000;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            last_grant <= 1'b1;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            err0       <= 1'b0;
            err1       <= 1'b0;
            rdata0     <= '0;
            rdata1     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        lat_id <= grant_id;
                        if (grant_id) begin
                            lat_we    <= we1;
                            lat_op    <= op1;
                            lat_addr  <= addr1;
                            lat_wdata <= wdata1;
                        end else begin
                            lat_we    <= we0;
                            lat_op    <= op0;
                            lat_addr  <= addr0;
                            lat_wdata <= wdata0;
                        end
                        if (ROUND_ROBIN && req0 && req1) begin
                            last_grant <= grant_id;
                        end
                        state <= ACCESS;
                    end
                end

                ACCESS: begin
                    if (lat_id) begin
                        ack1   <= 1'b1;
                        err1   <= illegal;
                        rdata1 <= load_ok ? memdataout : '0;
                    end else begin
                        ack0   <= 1'b1;
                        err0   <= illegal;
                        rdata0 <= load_ok ? memdataout : '0;
                    end
                    state <= RESP;
                end

                RESP: begin
                    ack0   <= 1'b0;
                    ack1   <= 1'b0;
                    err0   <= 1'b0;
                    err1   <= 1'b0;
                    rdata0 <= '0;
                    rdata1 <= '0;
                    state  <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed bench for dmem_arbiter with a little-endian byte memory.
`timescale 1ns/1ps

module tb_dmem_arbiter;

    logic        clk;
    logic        rst;
    logic        req0, we0, req1, we1;
    logic [2:0]  op0, op1;
    logic [8:0]  addr0, addr1;
    logic [31:0] wdata0, wdata1;

    // Round-robin instance, attached to the memory model
    logic        ack0, ack1, err0, err1, busy;
    logic [31:0] rdata0, rdata1;
    logic        memwrite, memread;
    logic [2:0]  memop;
    logic [8:0]  memaddr;
    logic [31:0] memdatain, memdataout;

    // Fixed-priority instance, sharing the request inputs
    logic        f_ack0, f_ack1, f_err0, f_err1, f_busy;
    logic [31:0] f_rdata0, f_rdata1;
    logic        f_memwrite, f_memread;
    logic [2:0]  f_memop;
    logic [8:0]  f_memaddr;
    logic [31:0] f_memdatain;
    logic [31:0] f_memdataout;

    int n_checks = 0;
    int n_fail   = 0;

    dmem_arbiter #(.ADDR_W(9), .DATA_W(32), .PRIORITY_MODE(0)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .op0(op0), .addr0(addr0), .wdata0(wdata0),
        .ack0(ack0), .err0(err0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .op1(op1), .addr1(addr1), .wdata1(wdata1),
        .ack1(ack1), .err1(err1), .rdata1(rdata1),
        .busy(busy),
        .memwrite(memwrite), .memread(memread), .memop(memop), .memaddr(memaddr),
        .memdatain(memdatain), .memdataout(memdataout)
    );

    dmem_arbiter #(.ADDR_W(9), .DATA_W(32), .PRIORITY_MODE(1)) dut_fp (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .op0(op0), .addr0(addr0), .wdata0(wdata0),
        .ack0(f_ack0), .err0(f_err0), .rdata0(f_rdata0),
        .req1(req1), .we1(we1), .op1(op1), .addr1(addr1), .wdata1(wdata1),
        .ack1(f_ack1), .err1(f_err1), .rdata1(f_rdata1),
        .busy(f_busy),
        .memwrite(f_memwrite), .memread(f_memread), .memop(f_memop), .memaddr(f_memaddr),
        .memdatain(f_memdatain), .memdataout(f_memdataout)
    );

    assign f_memdataout = 32'h0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte-addressed little-endian memory with combinational read
    logic [7:0] mem [512];
    logic       mem_clr;
    logic [7:0] rb0, rb1, rb2, rb3;

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 512; i++) mem[i] <= 8'h00;
        end else if (memwrite) begin
            mem[memaddr] <= memdatain[7:0];
            if (memop[1:0] == 2'b01 || memop[1:0] == 2'b10)
                mem[9'(memaddr + 9'd1)] <= memdatain[15:8];
            if (memop[1:0] == 2'b10) begin
                mem[9'(memaddr + 9'd2)] <= memdatain[23:16];
                mem[9'(memaddr + 9'd3)] <= memdatain[31:24];
            end
        end
    end

    always_comb begin
        rb0 = mem[memaddr];
        rb1 = mem[9'(memaddr + 9'd1)];
        rb2 = mem[9'(memaddr + 9'd2)];
        rb3 = mem[9'(memaddr + 9'd3)];
        case (memop)
            3'b000:  memdataout = {{24{rb0[7]}}, rb0};
            3'b100:  memdataout = {24'h0, rb0};
            3'b001:  memdataout = {{16{rb1[7]}}, rb1, rb0};
            3'b101:  memdataout = {16'h0, rb1, rb0};
            3'b010:  memdataout = {rb3, rb2, rb1, rb0};
            default: memdataout = 32'h0;
        endcase
    end

    typedef struct {
        bit        port;
        bit        we;
        bit [2:0]  op;
        bit [8:0]  addr;
        bit [31:0] wdata;
        bit        exp_mw;
        bit        exp_mr;
        bit        exp_err;
        bit [31:0] exp_rdata;
    } vec_t;

    localparam int NVEC = 17;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One single-port transaction: check ACCESS strobes, RESP ack, then return to IDLE
    task automatic run_txn(input int idx, input vec_t v);
        string t;
        t = $sformatf("v%0d", idx);
        if (v.port) begin
            req1 = 1'b1; we1 = v.we; op1 = v.op; addr1 = v.addr; wdata1 = v.wdata;
        end else begin
            req0 = 1'b1; we0 = v.we; op0 = v.op; addr0 = v.addr; wdata0 = v.wdata;
        end
        tick();
        check({t, "_busy_access"}, 32'(busy), 32'd1);
        check({t, "_memwrite"}, 32'(memwrite), 32'(v.exp_mw));
        check({t, "_memread"}, 32'(memread), 32'(v.exp_mr));
        check({t, "_memop"}, 32'(memop), 32'(v.op));
        check({t, "_memaddr"}, 32'(memaddr), 32'(v.addr));
        if (v.exp_mw) check({t, "_memdatain"}, memdatain, v.wdata);
        tick();
        check({t, "_ack"}, 32'(v.port ? ack1 : ack0), 32'd1);
        check({t, "_other_ack"}, 32'(v.port ? ack0 : ack1), 32'd0);
        check({t, "_err"}, 32'(v.port ? err1 : err0), 32'(v.exp_err));
        check({t, "_rdata"}, v.port ? rdata1 : rdata0, v.exp_rdata);
        req0 = 1'b0;
        req1 = 1'b0;
        tick();
        check({t, "_idle_ack"}, 32'({ack0, ack1}), 32'd0);
        check({t, "_idle_busy"}, 32'(busy), 32'd0);
        check({t, "_idle_rdata"}, rdata0 | rdata1, 32'h0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int g_rr [$];
        int g_fp [$];
        int exp_rr [4];

        //          port  we   op      addr    wdata         mw  mr  err rdata
        vecs[0]  = '{1'b0, 1'b1, 3'b010, 9'h010, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 32'h00000000};
        vecs[1]  = '{1'b1, 1'b0, 3'b000, 9'h013, 32'h0,        1'b0, 1'b1, 1'b0, 32'hFFFFFFDE};
        vecs[2]  = '{1'b1, 1'b0, 3'b101, 9'h012, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0000DEAD};
        vecs[3]  = '{1'b0, 1'b0, 3'b001, 9'h011, 32'h0,        1'b0, 1'b0, 1'b1, 32'h00000000};
        vecs[4]  = '{1'b0, 1'b1, 3'b100, 9'h010, 32'h000000AA, 1'b0, 1'b0, 1'b1, 32'h00000000};
        vecs[5]  = '{1'b0, 1'b0, 3'b010, 9'h010, 32'h0,        1'b0, 1'b1, 1'b0, 32'hDEADBEEF};
        vecs[6]  = '{1'b1, 1'b0, 3'b010, 9'h012, 32'h0,        1'b0, 1'b0, 1'b1, 32'h00000000};
        vecs[7]  = '{1'b0, 1'b0, 3'b011, 9'h000, 32'h0,        1'b0, 1'b0, 1'b1, 32'h00000000};
        vecs[8]  = '{1'b1, 1'b1, 3'b001, 9'h1FE, 32'h1234ABCD, 1'b1, 1'b0, 1'b0, 32'h00000000};
        vecs[9]  = '{1'b1, 1'b0, 3'b010, 9'h1FC, 32'h0,        1'b0, 1'b1, 1'b0, 32'hABCD0000};
        vecs[10] = '{1'b0, 1'b0, 3'b001, 9'h1FE, 32'h0,        1'b0, 1'b1, 1'b0, 32'hFFFFABCD};
        vecs[11] = '{1'b0, 1'b1, 3'b000, 9'h011, 32'h00000055, 1'b1, 1'b0, 1'b0, 32'h00000000};
        vecs[12] = '{1'b0, 1'b0, 3'b010, 9'h010, 32'h0,        1'b0, 1'b1, 1'b0, 32'hDEAD55EF};
        vecs[13] = '{1'b1, 1'b0, 3'b110, 9'h004, 32'h0,        1'b0, 1'b0, 1'b1, 32'h00000000};
        vecs[14] = '{1'b1, 1'b1, 3'b111, 9'h008, 32'h11111111, 1'b0, 1'b0, 1'b1, 32'h00000000};
        vecs[15] = '{1'b0, 1'b0, 3'b100, 9'h010, 32'h0,        1'b0, 1'b1, 1'b0, 32'h000000EF};
        vecs[16] = '{1'b1, 1'b1, 3'b101, 9'h100, 32'h22222222, 1'b0, 1'b0, 1'b1, 32'h00000000};

        rst = 1'b1; mem_clr = 1'b1;
        req0 = 1'b0; we0 = 1'b0; op0 = 3'b000; addr0 = 9'h0; wdata0 = 32'h0;
        req1 = 1'b0; we1 = 1'b0; op1 = 3'b000; addr1 = 9'h0; wdata1 = 32'h0;
        tick();
        tick();
        mem_clr = 1'b0;

        // Reset state
        check("rst_ack", 32'({ack0, ack1, f_ack0, f_ack1}), 32'd0);
        check("rst_err", 32'({err0, err1}), 32'd0);
        check("rst_rdata", rdata0 | rdata1, 32'h0);
        check("rst_busy", 32'({busy, f_busy}), 32'd0);
        check("rst_strobes", 32'({memwrite, memread}), 32'd0);
        check("rst_memaddr", 32'(memaddr), 32'd0);
        check("rst_memdatain", memdatain, 32'h0);
        rst = 1'b0;
        tick();

        // Directed single-port vectors
        for (int i = 0; i < NVEC; i++) run_txn(i, vecs[i]);

        // Both ports contending for four grants, on both arbitration modes
        do_reset();
        exp_rr = '{0, 1, 0, 1};
        req0 = 1'b1; we0 = 1'b0; op0 = 3'b010; addr0 = 9'h010;
        req1 = 1'b1; we1 = 1'b0; op1 = 3'b010; addr1 = 9'h1FC;
        for (int c = 0; c < 12; c++) begin
            tick();
            check("contend_no_double_ack", 32'(ack0 & ack1), 32'd0);
            if (ack0) begin
                g_rr.push_back(0);
                check("contend_rdata0", rdata0, 32'hDEAD55EF);
            end
            if (ack1) begin
                g_rr.push_back(1);
                check("contend_rdata1", rdata1, 32'hABCD0000);
            end
            if (f_ack0) g_fp.push_back(0);
            if (f_ack1) g_fp.push_back(1);
            check("fp_ack1_never", 32'(f_ack1), 32'd0);
        end
        req0 = 1'b0;
        req1 = 1'b0;
        check("rr_grant_count", 32'(g_rr.size()), 32'd4);
        check("fp_grant_count", 32'(g_fp.size()), 32'd4);
        for (int k = 0; k < 4; k++) begin
            if (k < g_rr.size()) check($sformatf("rr_grant%0d", k), 32'(g_rr[k]), 32'(exp_rr[k]));
            if (k < g_fp.size()) check($sformatf("fp_grant%0d", k), 32'(g_fp[k]), 32'd0);
        end
        tick();
        tick();
        check("contend_settled", 32'({busy, f_busy}), 32'd0);

        // Reset asserted during the ACCESS cycle of a store aborts it
        req1 = 1'b1; we1 = 1'b1; op1 = 3'b010; addr1 = 9'h020; wdata1 = 32'hCAFEF00D;
        tick();
        check("abort_busy", 32'(busy), 32'd1);
        check("abort_mw_before_rst", 32'(memwrite), 32'd1);
        rst = 1'b1;
        #1;
        check("abort_mw_suppressed", 32'(memwrite), 32'd0);
        req1 = 1'b0;
        tick();
        check("abort_busy_after", 32'(busy), 32'd0);
        check("abort_no_ack", 32'({ack0, ack1}), 32'd0);
        rst = 1'b0;
        tick();
        check("abort_no_late_ack", 32'({ack0, ack1, busy}), 32'd0);
        begin
            vec_t v;
            v = '{1'b1, 1'b0, 3'b010, 9'h020, 32'h0, 1'b0, 1'b1, 1'b0, 32'h00000000};
            run_txn(100, v);
        end

        // Back-to-back: port 0 keeps req high and changes address in the ack cycle
        req0 = 1'b1; we0 = 1'b0; op0 = 3'b010; addr0 = 9'h010;
        tick();
        check("b2b_access1_addr", 32'(memaddr), 32'h010);
        tick();
        check("b2b_ack1", 32'(ack0), 32'd1);
        check("b2b_rdata1", rdata0, 32'hDEAD55EF);
        addr0 = 9'h1FC;
        tick();
        check("b2b_idle_busy", 32'(busy), 32'd0);
        check("b2b_idle_ack", 32'(ack0), 32'd0);
        tick();
        check("b2b_access2_busy", 32'(busy), 32'd1);
        check("b2b_access2_addr", 32'(memaddr), 32'h1FC);
        check("b2b_access2_rd", 32'(memread), 32'd1);
        tick();
        check("b2b_ack2", 32'(ack0), 32'd1);
        check("b2b_rdata2", rdata0, 32'hABCD0000);
        req0 = 1'b0;
        tick();
        check("b2b_done", 32'({busy, ack0}), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
